uart_tx: RTL and testbench
==========================

# uart_tx

Asynchronous serial transmitter: sends one 8-bit byte per request as a standard 8N1 frame (start bit, 8 data bits LSB first, stop bit) on a single line. Bit time is fixed at build time by a clock-cycles-per-bit parameter. It sits beneath the command/data sequencers, which poll `ready` and pulse or hold `start` to push bytes to a PC serial port.

## Interface
- BAUD, default 434 — clock cycles per bit, integer ≥ 2. 434 gives 115200 baud at 50 MHz; other presets are 868, 1302, 2604, 5208, 10417, 20833, 41667, 83333, 166667.
- clk  input  1  — system clock; all logic is rising-edge.
- rst  input  1  — asynchronous, active-low reset.
- data  input  8  — byte to send; sampled only at frame acceptance.
- start  input  1  — transmit request, level-sensitive.
- ready  output  1  — 1 = idle and able to accept; 0 = frame in progress.
- tx  output  1  — serial line, idles high; registered output.

## Operation
- Reset (rst=0, asynchronous): tx=1, ready=1, FSM in IDLE, baud counter=0, bit index=0. The shift register content is don't-care.
- FSM states are IDLE, START, DATA, STOP (and PARITY when configured).
- IDLE: tx=1, ready=1. On a clk edge where start=1:
  - latch data into an internal shift register;
  - clear the baud counter;
  - go to START, setting tx=0 and ready=0 on that same edge.
- START: hold tx=0 for BAUD cycles, then go to DATA with bit index 0.
- DATA: drive tx=data[i] for BAUD cycles each, for i=0..7 (LSB first). After bit 7, go to STOP (or PARITY).
- STOP: tx=1 for BAUD cycles. At the end, go to IDLE with ready=1.
- The baud counter counts 0..BAUD-1. The state or bit advances on the edge where the counter equals BAUD-1, and the counter wraps to 0 on that edge. The counter is $clog2(BAUD) bits wide.
- start and data changes during a frame are ignored. The latched byte is what gets transmitted.
- If start stays high continuously, frames go back-to-back. IDLE lasts exactly one clk cycle between frames (ready=1 for that one cycle), then the next frame is accepted.
- start asserted on the same edge that STOP finishes is not accepted. Acceptance requires the FSM to already be in IDLE.
- Reset mid-frame aborts immediately: tx=1, ready=1, and no partial completion.

## Timing
- Acceptance latency: tx falls on the clk edge that samples start=1 in IDLE.
- Frame length: exactly 10×BAUD cycles from tx falling to ready rising (11×BAUD with parity).
- Bit k (0=start, 1..8=data, 9=stop) occupies cycles [k×BAUD, (k+1)×BAUD) after acceptance.
- Minimum start-to-start period: 10×BAUD+1 cycles.
- ready is registered and changes only on the acceptance edge and the frame-end edge.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for BAUD cycles, giving an 8E1 frame of 11×BAUD cycles.
  - Undefined: 8N1 frame, no PARITY state, and no parity logic is synthesized.

## Test plan
- Reset: hold rst=0 with start=1 → tx=1, ready=1 throughout. After release, the first frame starts on the first clk edge.
- Single byte: BAUD=4, data=0xA5, start pulsed for 1 cycle → tx sequence per 4 cycles is 0,1,0,1,0,0,1,0,1,1. ready is low for exactly 40 cycles.
- Data change mid-frame: start with 0x3C, then change data to 0xFF two cycles later → the line carries 0x3C.
- Held start: BAUD=4, start=1 continuously, data=0x00 → consecutive frames 41 cycles apart, with ready high for 1 cycle between them.
- Mid-frame reset: assert rst=0 during data bit 3 → tx=1 and ready=1 immediately (asynchronously). A new frame sends correctly after release.
- Parity (UART_TX_PARITY_EN defined): data=0x07 → parity bit 1, and ready is low for 11×BAUD cycles.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a build-time cycles-per-bit divider; ready is high only while idle.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx #(
  parameter int unsigned BAUD = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       ready,
  output logic       tx
);

  // state  | meaning
  // IDLE   | line high, ready high, waiting for start
  // START  | start bit (tx=0)
  // DATA   | data bit idx, LSB first
  // PARITY | even parity of the latched byte (only with UART_TX_PARITY_EN)
  // STOP   | stop bit (tx=1); ready rises when it ends
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam int CW = (BAUD > 1) ? $clog2(BAUD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    sh, sh_nx;
  logic          tx_nx, ready_nx;
  logic          last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
      ready <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      sh    <= sh_nx;
      tx    <= tx_nx;
      ready <= ready_nx;
    end
  end

  // tx and ready are computed one edge ahead so both leave the flops directly.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    sh_nx    = sh;
    tx_nx    = tx;
    ready_nx = ready;
    last     = (cnt == CNT_MAX);

    if (state != IDLE) cnt_nx = last ? '0 : cnt + 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          sh_nx    = data;
          cnt_nx   = '0;
          state_nx = START;
          tx_nx    = 1'b0;
          ready_nx = 1'b0;
        end
      end
      START: begin
        if (last) begin
          state_nx = DATA;
          idx_nx   = '0;
          tx_nx    = sh[0];
        end
      end
      DATA: begin
        if (last) begin
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nx = PARITY;
            tx_nx    = ^sh;
`else
            state_nx = STOP;
            tx_nx    = 1'b1;
`endif
          end else begin
            idx_nx = idx + 3'd1;
            tx_nx  = sh[idx + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (last) begin
          state_nx = STOP;
          tx_nx    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (last) begin
          state_nx = IDLE;
          ready_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
        ready_nx = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at BAUD=4: table of known frames, held-start and reset
// corner cases, then random bytes checked against a frame-level reference model.
module tb_uart_tx;

  localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       start;
  logic       ready;
  logic       tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = -1000;

  uart_tx #(.BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .data(data), .start(start), .ready(ready), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] d;
    bit         hold;
    bit         scramble;
    logic [0:9] exp8n1;   // start, d0..d7, stop
    logic       exp_par;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: bit k of the line for k = 0..NB-1.
  function automatic logic [0:10] model_frame(input logic [7:0] d);
    logic [0:10] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction

  // Precondition: DUT idle, #1 after an edge. Requests d, then checks every line cycle.
  task automatic run_frame(input logic [7:0] d, input logic [0:10] fr, input bit hold,
                           input bit scramble, input bit prev_hold);
    int bad, rlow;
    data  = d;
    start = 1'b1;
    tick();
    if (prev_hold) chk("start_to_start", cyc - last_acc, NB*BAUD + 1);
    last_acc = cyc;
    if (!hold) start = 1'b0;
    rlow = 0;
    for (int k = 0; k < NB; k++) begin
      bad = 0;
      for (int c = 0; c < BAUD; c++) begin
        if (tx !== fr[k]) bad++;
        if (ready === 1'b0) rlow++;
        if (scramble) data = (k == 0 && c < 3) ? 8'hFF : 8'($urandom);
        tick();
      end
      chk($sformatf("bit%0d_d%02h", k, d), bad, 0);
    end
    chk("ready_low_cycles", rlow, NB*BAUD);
    chk("frame_end_ready", ready, 1'b1);
    chk("frame_end_tx", tx, 1'b1);
  endtask

  vec_t vecs[6];
  logic [0:10] fr;
  logic [7:0] rd;
  bit ph, h;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 10'b0101001011, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 10'b0001111001, 1'b0};
    vecs[2] = '{8'h07, 1'b0, 1'b0, 10'b0111000001, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 10'b0000000001, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 10'b0000000001, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 10'b0000000011, 1'b1};

    rst = 1'b0; start = 1'b1; data = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("reset_tx", tx, 1'b1);
      chk("reset_ready", ready, 1'b1);
    end
    rst = 1'b1;

    ph = 1'b0;
    foreach (vecs[i]) begin
`ifdef UART_TX_PARITY_EN
      fr = {vecs[i].exp8n1[0:8], vecs[i].exp_par, 1'b1};
`else
      fr = {vecs[i].exp8n1, 1'b1};
`endif
      run_frame(vecs[i].d, fr, vecs[i].hold, vecs[i].scramble, ph);
      ph = vecs[i].hold;
    end

    // Reset during data bit 3 must take effect without a clock edge.
    rd = 8'($urandom);
    data = rd; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4*BAUD + 1) tick();
    chk("pre_reset_bit3", tx, rd[3]);
    chk("pre_reset_ready", ready, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_tx", tx, 1'b1);
    chk("async_reset_ready", ready, 1'b1);
    tick();
    rst = 1'b1;
    rd = 8'($urandom);
    run_frame(rd, model_frame(rd), 1'b0, 1'b0, 1'b0);

    ph = 1'b0;
    for (int n = 0; n < 20; n++) begin
      rd = 8'($urandom);
      h  = ($urandom_range(0, 2) == 0);
      if (!ph) repeat ($urandom_range(0, 3)) tick();
      run_frame(rd, model_frame(rd), h, ($urandom_range(0, 3) == 0), ph);
      ph = h;
    end
    start = 1'b0;
    tick();
    chk("final_idle_ready", ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
